// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: command-driven COPY/FILL/ADDI/SUM sequencer for a 16x8 register file.
// Define REGSEQ_SAT_EN to make ADDI results and the SUM accumulator saturate instead of wrap.
module regfile_seq_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_t;
    localparam logic [1:0] OP_COPY = 2'd0, OP_FILL = 2'd1, OP_SUM = 2'd3;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q, idx_d;
    logic [DATA_W-1:0] imm_q, acc_q, acc_d;
    logic              accept;

    function automatic logic [DATA_W-1:0] add_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef REGSEQ_SAT_EN
        return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
        return s[DATA_W-1:0];
`endif
    endfunction

    assign accept = cmd_valid && state_q == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            imm_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            if (accept) begin
                op_q  <= cmd_op;
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                len_q <= cmd_len;
                imm_q <= cmd_imm;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        rf_read_reg   = '0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_write_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                rf_read_reg   = op_q == OP_FILL ? '0 : src_q + idx_q;
                rf_write_reg  = dst_q + idx_q;
                rf_write_en   = op_q != OP_SUM;
                rf_write_data = op_q == OP_COPY ? rf_read_data :
                                op_q == OP_FILL ? imm_q : add_fn(rf_read_data, imm_q);
                acc_d         = op_q == OP_SUM ? add_fn(acc_q, rf_read_data) : acc_q;
                idx_d         = idx_q + 1'b1;
                if (idx_q == len_q) state_d = op_q == OP_SUM ? WB : DONE;
            end
            WB: begin
                rf_write_reg  = dst_q;
                rf_write_data = acc_q;
                rf_write_en   = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb_regfile_seq_ctrl: directed bench with a behavioural register file and a write scoreboard.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_regfile_seq_ctrl;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
    logic [7:0] cmd_imm = '0;
    logic       cmd_ready, busy, done, rf_write_en;
    logic [3:0] rf_read_reg, rf_write_reg;
    logic [7:0] rf_read_data, rf_write_data;

    logic [7:0] mem [16];
    logic [7:0] exp_mem [16];
    logic       do_preload = 1'b1;
    int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, done_cyc = 0, exp_done_rel = 0;
    bit done_seen = 1'b0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] r;
    } wr_t;
    wr_t sb [$];

    regfile_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_imm(cmd_imm),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .rf_write_en(rf_write_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_read_data = mem[rf_read_reg];
    always @(posedge clk)
        if (do_preload) for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
        else if (rf_write_en) mem[rf_write_reg] <= rf_write_data;

    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef REGSEQ_SAT_EN
        return s[8] ? 8'hFF : s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    // Relative cycle 1 is the interval right after the accept edge.
    always @(negedge clk) begin
        wr_t e;
        if (rf_write_en) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", rf_write_reg, rf_write_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                `CHK("wr_addr", rf_write_reg, e.a)
                `CHK("wr_data", rf_write_data, e.d)
                `CHK("wr_cycle", cyc - acc_cyc, int'(e.r))
            end
        end
        if (done) begin
            `CHK("done_cycle", cyc - acc_cyc, exp_done_rel)
            done_cyc  = cyc;
            done_seen = 1'b1;
        end
        if (busy) `CHK("ready_while_busy", cmd_ready, 1'b0)
    end

    task automatic preload();
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] l, input logic [7:0] im, input int maxw);
        int n;
        logic [7:0] acc, v;
        logic [3:0] a, w;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_imm = im;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        `CHK("accept", cmd_ready, 1'b1)
        acc_cyc      = cyc;
        exp_done_rel = int'(l) + (op == 2'd3 ? 3 : 2);
        acc          = '0;
        for (int i = 0; i <= int'(l); i++) begin
            a   = s + 4'(i);
            w   = d + 4'(i);
            v   = op == 2'd0 ? exp_mem[a] : op == 2'd1 ? im : add8(exp_mem[a], im);
            acc = add8(acc, exp_mem[a]);
            if (op != 2'd3 && i < maxw) begin
                sb.push_back('{w, v, 8'(i + 1)});
                exp_mem[w] = v;
            end
        end
        if (op == 2'd3) begin
            sb.push_back('{d, acc, 8'(int'(l) + 2)});
            exp_mem[d] = acc;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_seen && n < 64) begin
            @(negedge clk);
            n++;
        end
        `CHK("done_seen", done_seen, 1'b1)
        done_seen = 1'b0;
        @(negedge clk);
        `CHK("busy_after_done", busy, 1'b0)
        `CHK("ready_after_done", cmd_ready, 1'b1)
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) `CHK("mem", mem[i], exp_mem[i])
    endtask

    initial begin
        repeat (3) @(negedge clk);
        `CHK("rst_ready", cmd_ready, 1'b1)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_we", rf_write_en, 1'b0)
        `CHK("rst_rreg", rf_read_reg, 4'h0)
        `CHK("rst_wreg", rf_write_reg, 4'h0)
        `CHK("rst_wdata", rf_write_data, 8'h00)
        rst = 1'b0;
        preload();
        issue(2'd0, 4'd0, 4'd8, 4'd3, 8'h00, 16);
        wait_done();
        check_mem();
        issue(2'd1, 4'd0, 4'd14, 4'd3, 8'hAA, 16);
        wait_done();
        `CHK("fill_wrap_reg0", mem[0], 8'hAA)
        `CHK("fill_reg2", mem[2], 8'h02)
        check_mem();
        preload();
        issue(2'd2, 4'd15, 4'd15, 4'd0, 8'hF5, 16);
        wait_done();
`ifdef REGSEQ_SAT_EN
        `CHK("addi_reg15", mem[15], 8'hFF)
`else
        `CHK("addi_reg15", mem[15], 8'h04)
`endif
        preload();
        issue(2'd3, 4'd0, 4'd3, 4'd15, 8'h00, 16);
        wait_done();
        `CHK("sum_reg3", mem[3], 8'h78)
        check_mem();
        preload();
        issue(2'd1, 4'd0, 4'd0, 4'd15, 8'hFF, 16);
        wait_done();
        issue(2'd3, 4'd0, 4'd5, 4'd15, 8'h00, 16);
        wait_done();
`ifdef REGSEQ_SAT_EN
        `CHK("sum_ff_reg5", mem[5], 8'hFF)
`else
        `CHK("sum_ff_reg5", mem[5], 8'hF0)
`endif
        preload();
        issue(2'd0, 4'd0, 4'd1, 4'd2, 8'h00, 16);
        wait_done();
        `CHK("overlap_reg3", mem[3], 8'h00)
        check_mem();
        preload();
        issue(2'd0, 4'd0, 4'd8, 4'd7, 8'h00, 2);
        @(negedge clk);
        rst = 1'b1;
        exp_done_rel = 0;
        @(negedge clk);
        `CHK("abort_we", rf_write_en, 1'b0)
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_ready", cmd_ready, 1'b1)
        `CHK("abort_done", done, 1'b0)
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_mem();
        preload();
        issue(2'd1, 4'd0, 4'd4, 4'd1, 8'h33, 16);
        issue(2'd0, 4'd4, 4'd6, 4'd1, 8'h00, 16);
        done_seen = 1'b0;
        `CHK("accept_after_done", acc_cyc, done_cyc + 1)
        wait_done();
        `CHK("held_copy_reg7", mem[7], 8'h33)
        check_mem();
        `CHK("sb_empty", sb.size(), 0)
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
